// File: rtl/mem_bus_router.sv
// mem_bus_router: single-master to N_SLV-slave router with address-mask
// decode, per-access wait counter with timeout error, and an error address log.
`timescale 1ns/1ps
module mem_bus_router #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int N_SLV   = 3,
  parameter logic [N_SLV*ADDR_W-1:0] BASE = {16'h6000, 16'h4000, 16'h0000},
  parameter logic [N_SLV*ADDR_W-1:0] MASK = {16'hFFFF, 16'hE000, 16'hC000},
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m_req,
  input  logic                    m_we,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_ready,
  output logic                    m_err,
  output logic [N_SLV-1:0]        s_sel,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  input  logic [N_SLV-1:0]        s_ready,
  output logic [ADDR_W-1:0]       err_addr
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [IDX_W-1:0]    r_idx;
  logic                r_err;
  logic                r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic [N_SLV-1:0]    r_sel;
  logic [ADDR_W-1:0]   r_err_addr;

  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic [N_SLV-1:0]    w_onehot;
  logic                w_sready;
  logic [DATA_W-1:0]   w_srdata;

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((m_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  // One-hot select for the decoded index, and the latched slave's response.
  always_comb begin
    w_onehot = '0;
    w_sready = 1'b0;
    w_srdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      w_onehot[i] = (w_idx == IDX_W'(i));
      if (r_idx == IDX_W'(i)) begin
        w_sready = s_ready[i];
        w_srdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with registered master/slave outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_sel      <= '0;
      r_err_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (m_req) begin
            r_we    <= m_we;
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_idx   <= w_idx;
            r_cnt   <= '0;
            if (w_hit) begin
              r_sel   <= w_onehot;
              r_state <= ACCESS;
            end else begin
              // Unmapped: respond immediately with an error.
              r_err      <= 1'b1;
              r_rdata    <= '0;
              r_ready    <= 1'b1;
              r_err_addr <= m_addr;
              r_state    <= RESP;
            end
          end
        end
        ACCESS: begin
          if (w_sready) begin
            // Slave completion beats a simultaneous timeout.
            r_rdata <= r_we ? '0 : w_srdata;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_sel   <= '0;
            r_state <= RESP;
          end else if (r_cnt == TO_LAST) begin
            r_rdata    <= '0;
            r_err      <= 1'b1;
            r_ready    <= 1'b1;
            r_sel      <= '0;
            r_err_addr <= r_addr;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          // Requests seen here are not taken; IDLE accepts them next cycle.
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_sel   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m_rdata  = r_rdata;
  assign m_ready  = r_ready;
  assign m_err    = r_err;
  assign s_sel    = r_sel;
  assign s_we     = r_we;
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign err_addr = r_err_addr;

endmodule

// File: doc/mem_bus_router.md
MEM_BUS_ROUTER -- requirements
Module: mem_bus_router

Parameters
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- N_SLV, 3, number of slave ports, 1..8.
- BASE, {16'h6000,16'h4000,16'h0000}, packed N_SLV*ADDR_W region bases, slave 0 in the LSBs.
- MASK, {16'hFFFF,16'hE000,16'hC000}, packed N_SLV*ADDR_W region masks.
- TIMEOUT, 15, maximum ACCESS cycles before an error response, 1..255.

Interface
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all state changes on its rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- m_req, in, 1, master request.
- m_we, in, 1, write enable.
- m_addr, in, ADDR_W, address.
- m_wdata, in, DATA_W, write data.
- m_rdata, out, DATA_W, read data.
- m_ready, out, 1, one-cycle completion pulse.
- m_err, out, 1, error flag, qualified by m_ready.
- s_sel, out, N_SLV, one-hot slave select.
- s_we, out, 1, registered write enable.
- s_addr, out, ADDR_W, registered address.
- s_wdata, out, DATA_W, registered write data.
- s_rdata, in, N_SLV*DATA_W, packed slave read data.
- s_ready, in, N_SLV, per-slave completion.
- err_addr, out, ADDR_W, address of the most recent errored access.

Function
REQ-003 Slave i SHALL hit when (m_addr & MASK[i]) == BASE[i].
- Overlapping hits: the lowest index wins.
- Default map: 0x0000-0x3FFF to slave 0, 0x4000-0x5FFF to slave 1, 0x6000 only to slave 2.
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-005 IDLE with m_req=1:
- Latch m_we, m_addr, m_wdata and the winning index.
- On a hit, go to ACCESS.
- On no hit, go to RESP with the error bit set.
- m_req=0 keeps IDLE.
REQ-006 s_sel SHALL be one-hot at the latched index only while in ACCESS, and all-zero otherwise.
- s_we, s_addr and s_wdata SHALL hold the latched values throughout ACCESS.
REQ-007 ACCESS SHALL sample s_ready[idx] every cycle. When it is 1:
- Capture s_rdata[idx] for a read, or 0 for a write.
- Clear the error bit and go to RESP.
REQ-008 The ACCESS wait counter:
- Is 8-bit and cleared on entry to ACCESS.
- Increments each ACCESS cycle in which s_ready[idx]=0.
- When it equals TIMEOUT-1 with s_ready[idx]=0: set the error bit, set captured data to 0, go to RESP.
REQ-009 s_ready[idx]=1 in the timeout cycle SHALL win: normal completion, no error.
REQ-010 RESP SHALL assert m_ready=1 for exactly one cycle, with m_err equal to the error bit, then return to IDLE.
- m_req sampled during RESP SHALL NOT be accepted; acceptance happens in the following IDLE cycle.
REQ-011 m_rdata SHALL be driven from a register and hold its value until the next RESP.
REQ-012 Latency from the m_req-sampled edge:
- Zero-wait hit: m_ready 2 cycles later.
- Unmapped: m_ready 1 cycle later.
- Timeout: m_ready TIMEOUT+1 cycles later.
REQ-013 Master and slave inputs SHALL be ignored after acceptance:
- m_req deasserted or m_* changed mid-transaction has no effect; the access completes.
- s_ready from non-selected slaves is ignored.
REQ-014 err_addr SHALL load the latched address on every RESP with the error bit set, and is otherwise unchanged.

Reset
REQ-015 rst_n=0 SHALL immediately, without waiting for clk:
- Force IDLE and clear the wait counter.
- Clear m_ready, m_err, s_sel, s_we, s_addr, s_wdata, m_rdata and err_addr to 0.
REQ-016 Reset asserted mid-ACCESS SHALL abort the transaction with no m_ready pulse.
- The first request accepted after release starts a fresh transaction.

Verification
REQ-017 Read hit: m_req=1, m_addr=0x1234, m_we=0, s_ready[0]=1 with rdata 0xBEEF.
- Expected: s_sel=001 for 1 cycle, then m_ready=1, m_rdata=0xBEEF, m_err=0.
REQ-018 Write to 0x4100 with m_wdata=0xA5A5, s_ready[1] low for 3 cycles.
- Expected: s_sel=010 for 4 cycles with s_wdata=0xA5A5, then m_ready=1, m_err=0, m_rdata=0.
REQ-019 Unmapped access to 0x6001.
- Expected: s_sel stays 000; the next cycle m_ready=1, m_err=1, err_addr=0x6001.
REQ-020 Access to 0x6000 with s_ready[2] held 0.
- Expected: 15 ACCESS cycles, then m_ready=1, m_err=1, m_rdata=0.
- Repeat with s_ready[2] raised in the 15th cycle: m_err=0.
REQ-021 Overlap case: BASE[1]=0x0000, MASK[1]=0x0000, access to 0x0010.
- Expected: slave 0 selected, not slave 1.
REQ-022 rst_n pulsed low for 1 ns mid-ACCESS between clk edges.
- Expected: s_sel=0 immediately, no m_ready pulse; a back-to-back request afterwards completes normally.
